// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Picks one ready reservation station per issue slot (round-robin), drives
//   its operands into the shared OTTER_ALU, captures the result and holds it
//   on the common data bus request until the CDB arbiter accepts it.
//
//   Optional feature: define ALU_MUL_EN to run alu_fun 10 (multiply) for
//   MUL_LAT total execute cycles through an extra MUL state. Without the
//   macro, multiply is a single-cycle function like any other.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   rs_req                per-station request to issue
//   rs_v1/rs_v2/rs_fun    per-station operands and ALU function
//   rs_tag                per-station destination tag
//   rs_grant              one-hot issue acknowledge (combinational)
//   alu_v1/alu_v2/alu_fun operands/function to the ALU
//   alu_valid             operand-valid to the ALU
//   alu_result            ALU result (combinational from alu_* outputs)
//   cdb_req/cdb_grant     CDB request / accept handshake
//   cdb_val/cdb_tag       broadcast value and tag (INVALID_TAG when idle)
//   busy                  high whenever the FSM is not IDLE
module alu_issue_arbiter #(
  parameter int unsigned      NUM_RS      = 4,
  parameter int unsigned      MUL_LAT     = 3,
  parameter int unsigned      TAG_W       = 4,
  parameter logic [TAG_W-1:0] INVALID_TAG = '0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_RS-1:0]             rs_req,
  input  logic [NUM_RS-1:0][31:0]       rs_v1,
  input  logic [NUM_RS-1:0][31:0]       rs_v2,
  input  logic [NUM_RS-1:0][3:0]        rs_fun,
  input  logic [NUM_RS-1:0][TAG_W-1:0]  rs_tag,
  output logic [NUM_RS-1:0]             rs_grant,
  output logic [31:0]                   alu_v1,
  output logic [31:0]                   alu_v2,
  output logic [3:0]                    alu_fun,
  output logic                          alu_valid,
  input  logic [31:0]                   alu_result,
  output logic                          cdb_req,
  input  logic                          cdb_grant,
  output logic [31:0]                   cdb_val,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic                          busy
);

  localparam int unsigned PTR_W   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam logic [3:0]  FUN_MUL = 4'd10;

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]        op_v1_q, op_v1_d, op_v2_q, op_v2_d;
  logic [3:0]         op_fun_q, op_fun_d;
  logic [TAG_W-1:0]   op_tag_q, op_tag_d;
  logic [31:0]        res_val_q, res_val_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
`ifdef ALU_MUL_EN
  logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
`endif

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   pos_idx;
  int unsigned        pos;
  logic               issue;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pos        = 0;
    pos_idx    = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      pos     = (32'(rr_ptr_q) + i) % NUM_RS;
      pos_idx = PTR_W'(pos);
      if (!pick_found && rs_req[pos_idx]) begin
        pick_found = 1'b1;
        pick_idx   = pos_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_v1_d   = op_v1_q;
    op_v2_d   = op_v2_q;
    op_fun_d  = op_fun_q;
    op_tag_d  = op_tag_q;
    res_val_d = res_val_q;
    res_tag_d = res_tag_q;
`ifdef ALU_MUL_EN
    mul_cnt_d = mul_cnt_q;
`endif
    rs_grant  = '0;
    issue     = 1'b0;

    case (state_q)
      IDLE: issue = pick_found;
      EXEC: begin
`ifdef ALU_MUL_EN
        if (op_fun_q == FUN_MUL) begin
          // EXEC already counts as the first multiply cycle.
          state_d   = MUL;
          mul_cnt_d = CNT_W'(MUL_LAT - 2);
        end else
`endif
        begin
          res_val_d = alu_result;
          res_tag_d = op_tag_q;
          state_d   = HOLD;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (mul_cnt_q == '0) begin
          res_val_d = alu_result;
          res_tag_d = op_tag_q;
          state_d   = HOLD;
        end else begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end
      end
`endif
      HOLD: begin
        // The accept cycle doubles as the next issue slot.
        if (cdb_grant) begin
          if (pick_found) issue = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rs_grant[pick_idx] = 1'b1;
      op_v1_d  = rs_v1[pick_idx];
      op_v2_d  = rs_v2[pick_idx];
      op_fun_d = rs_fun[pick_idx];
      op_tag_d = rs_tag[pick_idx];
      rr_ptr_d = (32'(pick_idx) == NUM_RS - 1) ? '0 : pick_idx + 1'b1;
      state_d  = EXEC;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      op_v1_q   <= '0;
      op_v2_q   <= '0;
      op_fun_q  <= '0;
      op_tag_q  <= '0;
      res_val_q <= '0;
      res_tag_q <= '0;
`ifdef ALU_MUL_EN
      mul_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      op_v1_q   <= op_v1_d;
      op_v2_q   <= op_v2_d;
      op_fun_q  <= op_fun_d;
      op_tag_q  <= op_tag_d;
      res_val_q <= res_val_d;
      res_tag_q <= res_tag_d;
`ifdef ALU_MUL_EN
      mul_cnt_q <= mul_cnt_d;
`endif
    end
  end

  always_comb begin
`ifdef ALU_MUL_EN
    alu_valid = (state_q == EXEC) || (state_q == MUL);
`else
    alu_valid = (state_q == EXEC);
`endif
    alu_v1  = op_v1_q;
    alu_v2  = op_v2_q;
    alu_fun = op_fun_q;
    cdb_req = (state_q == HOLD);
    cdb_val = cdb_req ? res_val_q : '0;
    cdb_tag = cdb_req ? res_tag_q : INVALID_TAG;
    busy    = (state_q != IDLE);
  end

endmodule
